// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding, default width
// and the signed-overflow rule applied on completion.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Overflow depends only on operand signs and result sign; borrow_in never changes the rule.
    function automatic logic ovf_rule(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: D = A - B - Brin, Brout set on underflow.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Brin,
    output logic D,
    output logic Brout
);

    assign D     = A ^ B ^ Brin;
    assign Brout = (~A & B) | (~(A ^ B) & Brin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full_subtractor cell, borrow carried in a
// flip-flop, start/ready/done handshake with registered results.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int CW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_r;
    logic [1:0]       next_state_s;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] res_r;
    logic [CW-1:0]    cnt_r;
    logic             brw_r;
    logic             a_msb_r;
    logic             b_msb_r;
    logic             ready_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             ovf_r;
    logic             d_s;
    logic             brout_s;
    logic             accept_s;
    logic             finish_s;
    logic             ready_next_s;
    logic             done_next_s;

    full_subtractor u_cell (
        .A     (sa_r[0]),
        .B     (sb_r[0]),
        .Brin  (brw_r),
        .D     (d_s),
        .Brout (brout_s)
    );

    assign accept_s = (state_r == ST_IDLE) && start;
    assign finish_s = (state_r == ST_SHIFT) && (cnt_r == CNT_LAST);

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_SHIFT;
                else       next_state_s = ST_IDLE;
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_LAST) next_state_s = ST_DONE;
                else                   next_state_s = ST_SHIFT;
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Handshake decode from the upcoming state, registered below
    always_comb begin
        ready_next_s = 1'b0;
        done_next_s  = 1'b0;
        case (next_state_s)
            ST_IDLE:  ready_next_s = 1'b1;
            ST_SHIFT: ready_next_s = 1'b0;
            ST_DONE:  done_next_s  = 1'b1;
            default: begin
                ready_next_s = 1'b0;
                done_next_s  = 1'b0;
            end
        endcase
    end

    // Operand shifters, borrow FF, bit counter and partial result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sa_r    <= '0;
            sb_r    <= '0;
            res_r   <= '0;
            cnt_r   <= '0;
            brw_r   <= 1'b0;
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
        end else if (accept_s) begin
            sa_r    <= a;
            sb_r    <= b;
            res_r   <= '0;
            cnt_r   <= '0;
            brw_r   <= borrow_in;
            a_msb_r <= a[WIDTH-1];
            b_msb_r <= b[WIDTH-1];
        end else if (state_r == ST_SHIFT) begin
            sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
            sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
            res_r <= {d_s, res_r[WIDTH-1:1]};
            brw_r <= brout_s;
            // Hold on the last bit so the counter never wraps inside an operation.
            if (cnt_r != CNT_LAST) cnt_r <= cnt_r + CW'(1);
            else                   cnt_r <= cnt_r;
        end else begin
            sa_r  <= sa_r;
            sb_r  <= sb_r;
            res_r <= res_r;
            cnt_r <= cnt_r;
            brw_r <= brw_r;
        end
    end

    // Output registers: results update only when entering DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            ready_r <= ready_next_s;
            done_r  <= done_next_s;
            if (finish_s) begin
                diff_r   <= {d_s, res_r[WIDTH-1:1]};
                borrow_r <= brout_s;
                ovf_r    <= ovf_rule(a_msb_r, b_msb_r, d_s);
            end else begin
                diff_r   <= diff_r;
                borrow_r <= borrow_r;
                ovf_r    <= ovf_r;
            end
        end
    end

    assign ready  = ready_r;
    assign done   = done_r;
    assign diff   = diff_r;
    assign borrow = borrow_r;
    assign ovf    = ovf_r;

endmodule
